// File: rtl/mac_operand_sign_block.sv
// Operand conditioner for the configurable MAC: splits A/B into 8/16/32-bit lanes,
// converts signed lanes to magnitude and emits per-lane product-sign flags.
module mac_operand_sign_block #(
  parameter int unsigned MAC_CONF_WIDTH = 4,
  parameter int unsigned MAC_MIN_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [MAC_CONF_WIDTH-1:0]    cfg_in,
  input  logic [4*MAC_MIN_WIDTH-1:0]   A_in,
  input  logic [4*MAC_MIN_WIDTH-1:0]   B_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [MAC_CONF_WIDTH-1:0]    cfg_out,
  output logic [4*MAC_MIN_WIDTH-1:0]   A_mag,
  output logic [4*MAC_MIN_WIDTH-1:0]   B_mag,
  output logic                         C0_neg,
  output logic                         C1_neg,
  output logic                         C2_neg,
  output logic                         C3_neg
);

  localparam int unsigned W    = MAC_MIN_WIDTH;
  localparam int unsigned BusW = 4 * MAC_MIN_WIDTH;

  // Byte-sliced ~x+1 whose carry ripples only inside the active lane group.
  function automatic logic [BusW-1:0] to_mag(input logic [BusW-1:0] x, input logic sgn,
                                             input logic dual, input logic quad);
    logic [BusW-1:0] mag;
    logic [W:0]      sum;
    logic            cin;
    logic            cout;
    logic            neg;
    int unsigned     top;
    mag  = '0;
    cout = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (quad)      top = 3;
      else if (dual) top = (i < 2) ? 1 : 3;
      else           top = i;
      if (i == 0)      cin = 1'b1;
      else if (i == 2) cin = quad ? cout : 1'b1;
      else             cin = (dual | quad) ? cout : 1'b1;
      neg  = sgn & x[top*W + W - 1];
      sum  = {1'b0, ~x[i*W +: W]} + {{W{1'b0}}, cin};
      mag[i*W +: W] = neg ? sum[W-1:0] : x[i*W +: W];
      cout = sum[W];
    end
    return mag;
  endfunction

  logic                      s1_valid_q, s1_valid_d;
  logic [MAC_CONF_WIDTH-1:0] s1_cfg_q, s1_cfg_d;
  logic [BusW-1:0]           s1_a_q, s1_a_d;
  logic [BusW-1:0]           s1_b_q, s1_b_d;

  logic                      s2_valid_q, s2_valid_d;
  logic [MAC_CONF_WIDTH-1:0] s2_cfg_q, s2_cfg_d;
  logic [BusW-1:0]           s2_a_q, s2_a_d;
  logic [BusW-1:0]           s2_b_q, s2_b_d;
  logic [3:0]                flags_q, flags_d;

  logic       s1_load, s2_load;
  logic       sgn, dual, quad;
  logic [3:0] sign_a, sign_b, sign_x;

  assign s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready = ~s1_valid_q | s2_load;
  assign s1_load  = in_valid & in_ready;

  assign sgn  = s1_cfg_q[3];
  assign dual = (s1_cfg_q[1:0] == 2'b01);
  assign quad = (s1_cfg_q[1:0] == 2'b10);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      sign_a[i] = s1_a_q[i*W + W - 1];
      sign_b[i] = s1_b_q[i*W + W - 1];
    end
    sign_x = sign_a ^ sign_b;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_cfg_d   = s1_cfg_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (s1_load) begin
      s1_valid_d = 1'b1;
      s1_cfg_d   = cfg_in;
      s1_a_d     = A_in;
      s1_b_d     = B_in;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_cfg_d   = s2_cfg_q;
    s2_a_d     = s2_a_q;
    s2_b_d     = s2_b_q;
    flags_d    = flags_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_cfg_d   = s1_cfg_q;
      s2_a_d     = to_mag(s1_a_q, sgn, dual, quad);
      s2_b_d     = to_mag(s1_b_q, sgn, dual, quad);
      // Flags sit at the top lane slot of each group, where the negator reads them.
      if (!sgn)      flags_d = 4'b0000;
      else if (quad) flags_d = {sign_x[3], 3'b000};
      else if (dual) flags_d = {sign_x[3], 1'b0, sign_x[1], 1'b0};
      else           flags_d = sign_x;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_cfg_q   <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_cfg_q   <= '0;
      s2_a_q     <= '0;
      s2_b_q     <= '0;
      flags_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_cfg_q   <= s1_cfg_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      s2_cfg_q   <= s2_cfg_d;
      s2_a_q     <= s2_a_d;
      s2_b_q     <= s2_b_d;
      flags_q    <= flags_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign cfg_out   = s2_cfg_q;
  assign A_mag     = s2_a_q;
  assign B_mag     = s2_b_q;
  assign C0_neg    = flags_q[0];
  assign C1_neg    = flags_q[1];
  assign C2_neg    = flags_q[2];
  assign C3_neg    = flags_q[3];

endmodule
